// File: rtl/sipo_deser.sv
// sipo_deser: serial-in/parallel-out deserializer.
// Accumulates strobed serial bits into WIDTH-bit words (selectable bit order),
// holds each completed word on a registered output with a valid/ready
// handshake, and raises a sticky overrun flag when a word has to be dropped.
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       serial_in,
    input  logic                       bit_valid,
    input  logic                       clear,
    output logic [WIDTH-1:0]           parallel_out,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       overrun
);
    localparam int CW = $clog2(WIDTH+1);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic             last_bit;
    logic             take_bit;
    logic             complete;
    logic             accept;

    // Next shift-register value with the incoming bit included.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shreg_nxt = {shreg[WIDTH-2:0], serial_in};
        end else begin : g_lsb
            assign shreg_nxt = {serial_in, shreg[WIDTH-1:1]};
        end
    endgenerate

    // clear overrides a bit strobe on the same edge.
    assign take_bit = bit_valid && !clear;
    assign last_bit = (bit_count == CW'(WIDTH-1));
    assign complete = take_bit && last_bit;
    assign accept   = word_valid && word_ready;

    // Bit accumulator: shift register and partial-word bit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg     <= '0;
            bit_count <= '0;
        end else if (clear) begin
            shreg     <= '0;
            bit_count <= '0;
        end else if (bit_valid) begin
            shreg     <= shreg_nxt;
            bit_count <= last_bit ? '0 : bit_count + CW'(1);
        end
    end

    // Output word register, valid/ready handshake and sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parallel_out <= '0;
            word_valid   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (complete && (!word_valid || word_ready)) begin
                // Free slot, or the held word leaves this same edge.
                parallel_out <= shreg_nxt;
                word_valid   <= 1'b1;
            end else if (accept) begin
                // Consumed; the data stays visible but is no longer valid.
                word_valid <= 1'b0;
            end

            if (clear) begin
                overrun <= 1'b0;
            end else if (complete && word_valid && !word_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: MSB-first and LSB-first 8-bit instances plus a
// 12-bit MSB-first instance, all sharing one stimulus stream.
module tb_sipo_deser;
    logic        clk = 1'b0;
    logic        reset;
    logic        serial_in;
    logic        bit_valid;
    logic        clear;
    logic        word_ready;

    logic [7:0]  po_m, po_l;
    logic [11:0] po_w;
    logic        wv_m, wv_l, wv_w;
    logic [3:0]  bc_m, bc_l, bc_w;
    logic        ov_m, ov_l, ov_w;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
        .clear(clear), .parallel_out(po_m), .word_valid(wv_m),
        .word_ready(word_ready), .bit_count(bc_m), .overrun(ov_m));

    sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
        .clear(clear), .parallel_out(po_l), .word_valid(wv_l),
        .word_ready(word_ready), .bit_count(bc_l), .overrun(ov_l));

    sipo_deser #(.WIDTH(12), .MSB_FIRST(1'b1)) dut_w (
        .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
        .clear(clear), .parallel_out(po_w), .word_valid(wv_w),
        .word_ready(word_ready), .bit_count(bc_w), .overrun(ov_w));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    logic [7:0]  pat_ad;
    logic [7:0]  pat_3c;
    logic [11:0] pat_a5c;

    initial begin
        pat_ad  = 8'hAD;
        pat_3c  = 8'h3C;
        pat_a5c = 12'hA5C;
        reset = 1'b1; serial_in = 1'b0; bit_valid = 1'b0; clear = 1'b0; word_ready = 1'b0;
        tick(); tick();
        chk("rst_po", po_m, 8'h00);
        chk("rst_wv", wv_m, 1'b0);
        chk("rst_bc", bc_m, 4'd0);
        chk("rst_ov", ov_m, 1'b0);
        reset = 1'b0;
        tick();

        // Back-to-back bits, consumer always ready.
        word_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            send_bit(pat_ad[i]);
            if (i > 0) chk($sformatf("t1_bc%0d", 8 - i), bc_m, 64'(8 - i));
        end
        chk("t1_po_msb", po_m, 8'hAD);
        chk("t1_po_lsb", po_l, 8'hB5);
        chk("t1_wv", wv_m, 1'b1);
        chk("t1_bc0", bc_m, 4'd0);
        tick();
        chk("t1_wv_drop", wv_m, 1'b0);
        chk("t1_po_hold", po_m, 8'hAD);

        // Same word with two idle cycles after each bit.
        for (int i = 7; i >= 0; i--) begin
            send_bit(pat_ad[i]);
            if (i > 0) begin
                tick(); tick();
                chk($sformatf("t2_bc_idle%0d", 8 - i), bc_m, 64'(8 - i));
                chk($sformatf("t2_wv_idle%0d", 8 - i), wv_m, 1'b0);
            end
        end
        chk("t2_po_msb", po_m, 8'hAD);
        chk("t2_po_lsb", po_l, 8'hB5);
        chk("t2_wv", wv_m, 1'b1);
        tick();
        chk("t2_wv_drop", wv_m, 1'b0);

        // Stalled consumer: second word is dropped and overrun set.
        word_ready = 1'b0;
        for (int i = 7; i >= 0; i--) send_bit(pat_ad[i]);
        chk("t3_po1", po_m, 8'hAD);
        chk("t3_wv1", wv_m, 1'b1);
        chk("t3_ov1", ov_m, 1'b0);
        for (int i = 7; i >= 0; i--) send_bit(pat_3c[i]);
        chk("t3_po2", po_m, 8'hAD);
        chk("t3_wv2", wv_m, 1'b1);
        chk("t3_ov2", ov_m, 1'b1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t3_ov_clr", ov_m, 1'b0);
        chk("t3_po_clr", po_m, 8'hAD);
        chk("t3_wv_clr", wv_m, 1'b1);

        // Acceptance on exactly the completing edge.
        for (int i = 7; i >= 1; i--) send_bit(pat_3c[i]);
        word_ready = 1'b1;
        send_bit(pat_3c[0]);
        word_ready = 1'b0;
        chk("t4_po", po_m, 8'h3C);
        chk("t4_po_lsb", po_l, 8'h3C);
        chk("t4_wv", wv_m, 1'b1);
        chk("t4_ov", ov_m, 1'b0);
        tick();
        chk("t4_wv_hold", wv_m, 1'b1);
        word_ready = 1'b1; tick(); word_ready = 1'b0;
        chk("t4_wv_acc", wv_m, 1'b0);

        // Partial word flushed by clear; clear beats a simultaneous bit.
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        chk("t5_bc5", bc_m, 4'd5);
        clear = 1'b1; bit_valid = 1'b1; serial_in = 1'b1;
        tick();
        clear = 1'b0; bit_valid = 1'b0;
        chk("t5_bc_clr", bc_m, 4'd0);
        chk("t5_po_keep", po_m, 8'h3C);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        chk("t5_po_ff", po_m, 8'hFF);
        chk("t5_po_ff_lsb", po_l, 8'hFF);
        chk("t5_wv", wv_m, 1'b1);

        // Asynchronous reset between edges with a word held.
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        chk("t6_bc3", bc_m, 4'd3);
        reset = 1'b1;
        #2;
        chk("t6_po_rst", po_m, 8'h00);
        chk("t6_wv_rst", wv_m, 1'b0);
        chk("t6_bc_rst", bc_m, 4'd0);
        chk("t6_ov_rst", ov_m, 1'b0);
        reset = 1'b0;
        tick();

        // 12-bit word; the 8-bit instance completes after its first 8 bits.
        word_ready = 1'b1;
        for (int i = 11; i >= 0; i--) begin
            send_bit(pat_a5c[i]);
            if (i == 4) begin
                chk("t7_bc_w8", bc_w, 4'd8);
                chk("t7_po_m8", po_m, 8'hA5);
                chk("t7_wv_w8", wv_w, 1'b0);
            end
        end
        chk("t7_po_w", po_w, 12'hA5C);
        chk("t7_wv_w", wv_w, 1'b1);
        chk("t7_bc_w", bc_w, 4'd0);
        chk("t7_bc_m", bc_m, 4'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
